// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter: FSM states,
// output rounding/saturation and coefficient reset values.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

    // Round-half-up right shift followed by saturation to a signed out_w range.
    // Computed at 64 bits so neither the rounding add nor the bounds overflow.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 out_w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (shift > 0) begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

    function automatic int coef_reset(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: shifts the accumulator with round-half-up and
// clamps it into the signed output range.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W     = 18,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [OUT_W-1:0] y
);

    logic signed [63:0] acc_ext;

    assign acc_ext = {{(64 - ACC_W){acc_in[ACC_W-1]}}, acc_in};
    assign y       = OUT_W'(round_sat(acc_ext, OUT_SHIFT, OUT_W));

endmodule

// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR: one multiply-accumulate iterated over TAPS programmable
// coefficients, with valid/ready on both sides and rounded, saturated output.
module fir_filter_mac
    import fir_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 4,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   x_in,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    y_out
);

    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int DP_W  = DATA_W + COEF_W;

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [DATA_W-1:0] x_d [TAPS];
    logic signed [COEF_W-1:0] h_q [TAPS];
    logic signed [COEF_W-1:0] h_d [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AW-1:0]            i_q, i_d;
    logic signed [OUT_W-1:0]  y_q, y_d, y_rs;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] h_sel;
    logic signed [DP_W-1:0]   prod;
    logic                     accept;
    logic                     addr_ok;
    logic                     coef_ok;

    assign in_ready  = (state_q == IDLE) && !clear;
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;

    // A power-of-two tap count makes every address legal.
    generate
        if (TAPS == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = (int'(coef_addr) < TAPS);
        end
    endgenerate

    assign coef_ok = coef_we && (state_q == IDLE) && !clear && addr_ok;

    assign x_sel = x_q[i_q];
    assign h_sel = h_q[i_q];
    assign prod  = DP_W'(x_sel) * DP_W'(h_sel);

    fir_round_sat #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .acc_in (acc_q),
        .y      (y_rs)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        h_d         = h_q;
        acc_d       = acc_q;
        i_d         = i_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (coef_ok) begin
            h_d[coef_addr] = coef_wdata;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d[0] = x_in;
                    for (int k = 1; k < TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    acc_d   = '0;
                    i_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (i_q == AW'(TAPS - 1)) begin
                    i_d     = '0;
                    state_d = OUT;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            OUT: begin
                // A new result may replace one being consumed on this same edge.
                if (!out_valid_q || out_ready) begin
                    y_d         = y_rs;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            i_d         = '0;
            y_d         = '0;
            out_valid_d = 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            i_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                h_q[k] <= COEF_W'(coef_reset(k));
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= x_d[k];
                h_q[k] <= h_d[k];
            end
        end
    end

endmodule
